// File: rtl/divider_32bit_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : divider_32bit_seq                                              |
// | Purpose : sequential restoring divider, one quotient bit per clock,      |
// |           start/busy/done handshake. Define DIVIDER_SIGNED_EN for        |
// |           two's-complement operands.                                     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module divider_32bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Partial remainder never exceeds the already-consumed dividend bits, so
  // the shifted value always fits WIDTH bits and a WIDTH+1 subtract suffices.
  always_comb begin
    rem_sh   = {rem_q[WIDTH-2:0], work_q[WIDTH-1]};
    trial    = {1'b0, rem_sh} - {1'b0, dvs_q};
    rem_step = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
    q_step   = {work_q[WIDTH-2:0], ~trial[WIDTH]};
  end

`ifdef DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fix   = qneg_q ? -q_step   : q_step;
    r_fix   = rneg_q ? -rem_step : rem_step;
    qneg_d  = accept ? (dividend[WIDTH-1] ^ divisor[WIDTH-1]) : qneg_q;
    rneg_d  = accept ? dividend[WIDTH-1] : rneg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    q_fix   = q_step;
    r_fix   = rem_step;
  end
`endif

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_RUN: begin
        work_d = q_step;
        rem_d  = rem_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          quot_d  = q_fix;
          remo_d  = r_fix;
          dbz_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance overrides the DONE->IDLE return for back-to-back issue.
    if (accept) begin
      work_d = dvd_mag;
      rem_d  = '0;
      dvs_d  = dvs_mag;
      cnt_d  = '0;
      if (divisor == '0) begin
        state_d = S_DONE;
        quot_d  = '1;
        remo_d  = dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
